timer_scheduler: RTL and testbench

Time-multiplexed scheduler for a bank of N ladder-logic on-delay timers. It generates the 1 kHz millisecond tick from the system clock and sweeps every timer channel once per tick through a single shared incrementer/comparator. Each channel has a preset register written over a simple configuration port. It replaces per-rung timer instances in the PLC fabric: the rung logic drives `enable`, the scheduler returns `done`.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/timer_scheduler.sv | 143 ++++++++++++++
 tb/tb_timer_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared types and elaboration helpers for the ladder-timer scheduler.
//   sched_state_t : sweep sequencer states
//   DEF_CNT_W     : default accumulator/preset width
//   DEF_TICK_HZ   : default tick rate (1 ms tick)
//   calc_div()    : system clocks per tick
//   idx_w()       : width of a channel index, never below one bit
package timer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sched_state_t;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TICK_HZ = 1000;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock down to the timer tick.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   tick : registered one-cycle pulse, high in the cycle the count wraps to 0
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = DEF_TICK_HZ
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] count_r;

  // Free-running 0..DIV-1 counter; the tick flop fires together with the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
      tick    <= 1'b0;
    end else if (count_r == LAST) begin
      count_r <= '0;
      tick    <= 1'b1;
    end else begin
      count_r <= count_r + PW'(1'b1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: bank of N on-delay timers served by one shared
// incrementer/comparator, swept one channel per cycle after every tick.
//   clk, rst  : system clock, asynchronous active-low reset
//   enable    : per-channel run request; low clears acc and done at once
//   cfg_we    : preset write strobe
//   cfg_addr  : channel to write (out-of-range addresses are ignored)
//   cfg_data  : preset value in ticks
//   done      : registered per-channel elapsed flags
//   tick      : registered one-cycle tick pulse
//   busy      : high while a sweep is running (N_TIMERS cycles per tick)
//   overrun   : sticky, a tick landed while a sweep was still running
// DIV_CHECK=0 lets a bench elaborate an undersized divider on purpose.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = DEF_TICK_HZ,
  parameter int N_TIMERS  = 16,
  parameter int CNT_W     = DEF_CNT_W,
  parameter bit DIV_CHECK = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_TIMERS-1:0]        enable,
  input  logic                       cfg_we,
  input  logic [idx_w(N_TIMERS)-1:0] cfg_addr,
  input  logic [CNT_W-1:0]           cfg_data,
  output logic [N_TIMERS-1:0]        done,
  output logic                       tick,
  output logic                       busy,
  output logic                       overrun
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int AW  = idx_w(N_TIMERS);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_TIMERS - 1);

  // A sweep must finish before the next tick or ticks get dropped.
  if (DIV_CHECK && (DIV <= N_TIMERS + 1)) begin : g_div_check
    $error("timer_scheduler: CLK_HZ/TICK_HZ must exceed N_TIMERS+1");
  end

  sched_state_t     state_r;
  logic [AW-1:0]    idx_r;
  logic [CNT_W-1:0] acc_r    [N_TIMERS];
  logic [CNT_W-1:0] preset_r [N_TIMERS];
  logic [CNT_W-1:0] acc_sel_s;
  logic [CNT_W-1:0] preset_sel_s;
  logic [CNT_W-1:0] acc_inc_s;
  logic             sat_s;
  logic             reach_s;
  logic             cfg_hit_s;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Shared datapath for the channel under the sweep pointer. acc never
  // exceeds preset, so the increment cannot wrap.
  always_comb begin
    acc_sel_s    = acc_r[idx_r];
    preset_sel_s = preset_r[idx_r];
    acc_inc_s    = acc_sel_s + CNT_W'(1'b1);
    sat_s        = (acc_sel_s >= preset_sel_s);
    reach_s      = (acc_inc_s >= preset_sel_s);
  end

  assign cfg_hit_s = cfg_we && (int'(cfg_addr) < N_TIMERS);

  // Sweep sequencer: start on tick, walk every channel, flag ticks that arrive mid-sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (tick) begin
            state_r <= SWEEP;
            idx_r   <= '0;
            busy    <= 1'b1;
          end
        end
        SWEEP: begin
          // The colliding tick is simply not acted on; the sweep carries on.
          if (tick) begin
            overrun <= 1'b1;
          end
          if (idx_r == LAST_IDX) begin
            state_r <= IDLE;
            idx_r   <= '0;
            busy    <= 1'b0;
          end else begin
            idx_r <= idx_r + AW'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Channel state: disable clears in parallel, the swept channel takes the
  // shared result, and preset writes land after the sweep has read the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        acc_r[i]    <= '0;
        preset_r[i] <= '1;
        done[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_TIMERS; i++) begin
        if (!enable[i]) begin
          acc_r[i] <= '0;
          done[i]  <= 1'b0;
        end else if ((state_r == SWEEP) && (int'(idx_r) == i)) begin
          if (sat_s) begin
            done[i] <= 1'b1;
          end else begin
            acc_r[i] <= acc_inc_s;
            // done only falls through disable, even if the preset was raised
            done[i]  <= done[i] | reach_s;
          end
        end
        if (cfg_hit_s && (int'(cfg_addr) == i)) begin
          preset_r[i] <= cfg_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed phases plus random enable/preset traffic on a
// 4-channel instance, checked cycle by cycle against a tick-arithmetic model
// through a scoreboard queue; side instances cover overrun/async reset and
// out-of-range preset writes.
module tb_timer_scheduler;
  localparam int DIV = 16;
  localparam int N   = 4;

  logic       clk = 1'b0;
  logic       rst, cfg_we, tick, busy, overrun;
  logic [3:0] enable, done;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;

  logic        rst_o, we_o, tick_o, busy_o, ovr_o;
  logic [15:0] en_o, done_o;
  logic [3:0]  addr_o;
  logic [7:0]  data_o;

  logic       rst_i, we_i, tick_i, busy_i, ovr_i;
  logic [4:0] en_i, done_i;
  logic [2:0] addr_i;
  logic [7:0] data_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int at;

  typedef struct packed {
    logic       tick;
    logic       busy;
    logic       ovr;
    logic [3:0] done;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_exp, e_act;
  int   m_acc[N];
  int   m_preset[N];
  bit   m_done[N];

  always #5 clk = ~clk;

  timer_scheduler #(.CLK_HZ(16), .TICK_HZ(1), .N_TIMERS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .done(done), .tick(tick), .busy(busy), .overrun(overrun));

  timer_scheduler #(.CLK_HZ(8), .TICK_HZ(1), .N_TIMERS(16), .CNT_W(8), .DIV_CHECK(1'b0)) dut_ovr (
    .clk(clk), .rst(rst_o), .enable(en_o), .cfg_we(we_o), .cfg_addr(addr_o),
    .cfg_data(data_o), .done(done_o), .tick(tick_o), .busy(busy_o), .overrun(ovr_o));

  timer_scheduler #(.CLK_HZ(16), .TICK_HZ(1), .N_TIMERS(5), .CNT_W(8)) dut_ign (
    .clk(clk), .rst(rst_i), .enable(en_i), .cfg_we(we_i), .cfg_addr(addr_i),
    .cfg_data(data_i), .done(done_i), .tick(tick_i), .busy(busy_i), .overrun(ovr_i));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: ticks fall on multiples of DIV, channel i is evaluated
  // at the edge ending cycle T+1+i, presets change after that evaluation.
  task automatic model_step();
    exp_t e;
    if (!rst) begin
      cyc = 0;
      for (int i = 0; i < N; i++) begin
        m_acc[i] = 0; m_preset[i] = 255; m_done[i] = 0;
      end
      return;
    end
    cyc++;
    for (int i = 0; i < N; i++) begin
      int t;
      t = cyc - 2 - i;
      if (!enable[i]) begin
        m_acc[i] = 0; m_done[i] = 0;
      end else if (t >= DIV && (t % DIV) == 0) begin
        if (m_acc[i] >= m_preset[i]) m_done[i] = 1;
        else begin
          m_acc[i] = m_acc[i] + 1;
          if (m_acc[i] >= m_preset[i]) m_done[i] = 1;
        end
      end
    end
    if (cfg_we) m_preset[cfg_addr] = int'(cfg_data);
    e.tick = ((cyc % DIV) == 0);
    e.busy = (cyc > DIV) && (((cyc - 1) % DIV) < N);
    e.ovr  = 1'b0;
    for (int i = 0; i < N; i++) e.done[i] = m_done[i];
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: pop one expectation per cycle and compare away from the edge.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e_exp = exp_q.pop_front();
      e_act = {tick, busy, overrun, done};
      total++;
      if (e_act !== e_exp) begin
        bad++;
        $display("FAIL scoreboard cyc=%0d actual=%b required=%b", cyc, e_act, e_exp);
      end
    end
  end

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_rise(input int ch, output int when);
    when = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done[ch]) begin
        when = cyc;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    total++; bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b0; enable = 4'd0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
    rst_o = 1'b0; en_o = 16'd0; we_o = 1'b0; addr_o = 4'd0; data_o = 8'd0;
    rst_i = 1'b0; en_i = 5'd0; we_i = 1'b0; addr_i = 3'd0; data_i = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {57'd0, tick, busy, overrun, done}, 64'd0);
    rst = 1'b1;

    // basic count: preset[2]=3, enable before tick 64
    wait_to(58);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd3;
    wait_to(59);
    cfg_we = 1'b0; enable[2] = 1'b1;
    wait_rise(2, at);
    chk("basic_done_cycle", 64'(at), 64'd100);

    // one-cycle disable restarts the count
    wait_to(110);
    chk("done_persists", {63'd0, done[2]}, 64'd1);
    enable[2] = 1'b0;
    wait_to(111);
    chk("disable_clear", {63'd0, done[2]}, 64'd0);
    enable[2] = 1'b1;
    wait_rise(2, at);
    chk("restart_done_cycle", 64'(at), 64'd148);

    // preset 0 on channel 0
    wait_to(150);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd0;
    wait_to(151);
    cfg_we = 1'b0; enable[0] = 1'b1;
    wait_rise(0, at);
    chk("preset0_done_cycle", 64'(at), 64'd162);

    // collision: lower preset[1] 10->4 in the cycle channel 1 is swept at acc=5
    wait_to(165);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd10;
    wait_to(166);
    cfg_we = 1'b0; enable[1] = 1'b1;
    wait_to(258);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd4;
    wait_to(259);
    cfg_we = 1'b0;
    chk("collision_old_preset", {63'd0, done[1]}, 64'd0);
    wait_rise(1, at);
    chk("lowered_preset_cycle", 64'(at), 64'd275);

    // random enables and preset writes
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        int b;
        b = int'($urandom_range(0, 3));
        enable[b] = ~enable[b];
      end
      if ($urandom_range(0, 19) == 0) begin
        cfg_we   = 1'b1;
        cfg_addr = 2'($urandom_range(0, 3));
        cfg_data = 8'($urandom_range(0, 6));
      end
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;

    // overrun instance: DIV=8, 16 channels
    rst_o = 1'b1; en_o = 16'hFFFF;
    we_o = 1'b1; addr_o = 4'd3; data_o = 8'd0;
    @(posedge clk); #1;
    we_o = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("ovr_before_collision", {62'd0, ovr_o, busy_o}, 64'd1);
    @(posedge clk); #1;
    chk("ovr_set_sweep_continues", {62'd0, ovr_o, busy_o}, 64'd3);
    chk("ovr_inst_done3", {63'd0, done_o[3]}, 64'd1);
    repeat (19) @(posedge clk);
    #1;
    chk("ovr_sticky_mid_sweep", {62'd0, ovr_o, busy_o}, 64'd3);
    rst_o = 1'b0;
    #1;
    chk("async_reset_outputs", {45'd0, done_o, tick_o, busy_o, ovr_o}, 64'd0);

    // out-of-range writes ignored on a 5-channel instance
    rst_i = 1'b1; en_i = 5'b11111;
    for (int a = 5; a < 8; a++) begin
      we_i = 1'b1; addr_i = 3'(a); data_i = 8'd0;
      @(posedge clk); #1;
    end
    we_i = 1'b1; addr_i = 3'd4; data_i = 8'd1;
    @(posedge clk); #1;
    we_i = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    chk("ignored_writes_done", {59'd0, done_i}, 64'h10);
    chk("ign_no_overrun", {63'd0, ovr_i}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
